multi_edge_pulse_sync: RTL and testbench
========================================

// Module: multi_edge_pulse_sync
// PURPOSE
//  Multi-channel successor to the single-bit input-pulse detector.
//  Each channel synchronises an asynchronous level input (DIN) into the CLK domain and deglitches it.
//  It emits a one-cycle DOUT pulse on the selected edge(s) and keeps a saturating event count per channel.
//  Sits between asynchronous board inputs (buttons, external strobes) and synchronous control logic.
// PARAMETERS
//  WIDTH        4  number of independent channels (>=1)
//  SYNC_STAGES  2  synchroniser flops per channel (>=2)
//  FILTER       3  consecutive cycles a changed level must persist before acceptance (>=1)
//  EDGE_MODE    0  0 = rising, 1 = falling, 2 = both; 3 is illegal and is an elaboration error
//  CNT_W        8  width of each per-channel event counter (>=1)
// PORTS
//  CLK    in   1            single clock; all state updates on its rising edge
//  RST    in   1            asynchronous, active-low reset
//  DIN    in   WIDTH        asynchronous level inputs, one bit per channel
//  CLR    in   1            synchronous clear of all counters and OVF flags
//  DOUT   out  WIDTH        one-cycle event pulse per channel
//  LEVEL  out  WIDTH        filtered, synchronised level per channel
//  CNT    out  WIDTH*CNT_W  flattened counters; channel i occupies bits [i*CNT_W +: CNT_W]
//  OVF    out  WIDTH        sticky flag: an event arrived while the counter was saturated
// BEHAVIOUR
//  Reset (RST=0, asynchronous): all sync flops, filter counters, LEVEL, DOUT, CNT and OVF go to 0 immediately.
//   RST low mid-operation aborts any in-flight filtering; no pulse is emitted for it.
//  Sync: DIN[i] passes through SYNC_STAGES flops to give s[i]. Nothing samples DIN directly.
//  Filter, per channel:
//   - s != LEVEL: fcnt increments each cycle.
//   - s == LEVEL: fcnt is cleared to 0.
//   - When fcnt would reach FILTER: LEVEL toggles and fcnt clears in the same edge.
//   - A level held for fewer than FILTER cycles after sync never reaches LEVEL.
//  Edge: DOUT[i] is registered and is 1 for exactly the cycle after the edge on which LEVEL changes, if:
//   - EDGE_MODE=0 and the change is 0->1, or
//   - EDGE_MODE=1 and the change is 1->0, or
//   - EDGE_MODE=2 and the change is either direction.
//   Otherwise DOUT[i] is 0.
//  Latency: DIN change set up before edge e -> DOUT high after edge e+SYNC_STAGES+FILTER-1.
//   With defaults that is 5 rising edges, counting the sampling edge as edge 1.
//  Maximum event rate: one DOUT pulse per channel per FILTER cycles.
//   Channels are fully independent; simultaneous pulses on several channels are legal.
//  Counter, per channel:
//   - Increments on the edge that raises DOUT[i].
//   - Saturates at 2^CNT_W-1 and never wraps.
//   - An event at saturation sets OVF[i]; OVF stays set until CLR or reset.
//  CLR=1: every CNT is cleared to 0 and every OVF to 0.
//   If an event occurs in the same cycle as CLR, that counter becomes 1 (clear, then count) and OVF stays 0.
//   CLR does not affect the sync, filter, LEVEL or DOUT path.
//  DIN held high through reset release: s rises after SYNC_STAGES edges.
//   A rising event then follows after the normal latency, because LEVEL resets to 0.
// STRUCTURE
//  Package edge_sync_pkg:
//   - edge-mode constants EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2
//   - function clog2 for sizing the filter counter
//  Sub-module edge_sync_chan: one channel holding the sync chain, filter, edge detect, counter and OVF.
//   Parameters are passed through; the top is a generate loop over WIDTH plus CNT flattening.
//  Elaboration check: illegal EDGE_MODE, SYNC_STAGES<2 or FILTER<1 is reported with $error.
// TESTING
//  Defaults (WIDTH=4, SYNC=2, FILTER=3, rising, CNT_W=8); the bench logs cycle, RST, DIN, DOUT.
//  1. RST low 3 cycles, then DIN[0]=1 set 5ns before an edge
//     -> DOUT[0]=1 for exactly one cycle after the 5th edge; CNT0=1; LEVEL[0]=1.
//  2. DIN[1] high for 2 cycles only -> no DOUT[1], LEVEL[1] stays 0, CNT1=0.
//  3. DIN[2] toggles with high and low phases of 6 cycles each, 300 times
//     -> CNT2=255 after 255 pulses; OVF[2]=1 on the 256th; CNT2 stays 255.
//  4. CLR asserted in the same cycle as a DOUT[3] pulse -> CNT3=1, OVF[3]=0; other counters are 0.
//  5. EDGE_MODE=2 build, one DIN[0] high pulse of 10 cycles
//     -> two DOUT[0] pulses 10 cycles apart; CNT0=2.
//  6. RST driven low mid-filter (fcnt=2) -> all outputs 0 immediately; no pulse after release while DIN=0.
//  Randomised: 100 random DIN pulses per channel with a fixed seed
//   -> CNT and DOUT match a cycle-accurate reference model.

Source files
------------

// File: rtl/edge_sync_pkg.sv
// Shared constants and helpers for the multi-channel edge pulse synchroniser.
package edge_sync_pkg;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_BOTH = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/edge_sync_chan.sv
// One channel: synchroniser chain, persistence filter, edge pulse and
// saturating event counter with sticky overflow.
module edge_sync_chan
   import edge_sync_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER      = 3,
   parameter int EDGE_MODE   = EDGE_RISE,
   parameter int CNT_W       = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             din_i,
   input  logic             clr_i,
   output logic             dout_o,
   output logic             level_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             ovf_o
);

   localparam int FCNT_W = (clog2(FILTER) < 1) ? 1 : clog2(FILTER);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
   logic                   level_q, level_d;
   logic                   dout_q, dout_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic                   mismatch, accept;
   logic [CNT_W-1:0]       cnt_base;

   always_comb begin
      mismatch = sync_q[SYNC_STAGES-1] ^ level_q;
      accept   = mismatch && (fcnt_q == FCNT_LAST);
      fcnt_d   = (mismatch && !accept) ? fcnt_q + FCNT_W'(1) : '0;
      level_d  = level_q ^ accept;
      dout_d   = accept && ((EDGE_MODE == EDGE_BOTH) ||
                            (EDGE_MODE == EDGE_RISE && !level_q) ||
                            (EDGE_MODE == EDGE_FALL &&  level_q));
      // Clear takes effect first so a coincident event still counts as one.
      cnt_base = clr_i ? '0 : cnt_q;
      ovf_d    = clr_i ? 1'b0 : ovf_q;
      cnt_d    = cnt_base;
      if (dout_d) begin
         if (&cnt_base) ovf_d = 1'b1;
         else           cnt_d = cnt_base + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q  <= '0;
         fcnt_q  <= '0;
         level_q <= 1'b0;
         dout_q  <= 1'b0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], din_i};
         fcnt_q  <= fcnt_d;
         level_q <= level_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign dout_o  = dout_q;
   assign level_o = level_q;
   assign cnt_o   = cnt_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/multi_edge_pulse_sync.sv
// Multi-channel asynchronous-input edge detector: one edge_sync_chan per bit,
// counters flattened onto a single bus.
module multi_edge_pulse_sync
   import edge_sync_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER      = 3,
   parameter int EDGE_MODE   = EDGE_RISE,
   parameter int CNT_W       = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [WIDTH-1:0]       din_i,
   input  logic                   clr_i,
   output logic [WIDTH-1:0]       dout_o,
   output logic [WIDTH-1:0]       level_o,
   output logic [WIDTH*CNT_W-1:0] cnt_o,
   output logic [WIDTH-1:0]       ovf_o
);

   if (EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_BOTH || SYNC_STAGES < 2 || FILTER < 1)
   begin : g_bad_param
      $error("multi_edge_pulse_sync: illegal EDGE_MODE, SYNC_STAGES or FILTER");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      edge_sync_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER      (FILTER),
         .EDGE_MODE   (EDGE_MODE),
         .CNT_W       (CNT_W)
      ) u_chan (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .din_i   (din_i[i]),
         .clr_i   (clr_i),
         .dout_o  (dout_o[i]),
         .level_o (level_o[i]),
         .cnt_o   (cnt_o[i*CNT_W +: CNT_W]),
         .ovf_o   (ovf_o[i])
      );
   end

endmodule

// File: tb/tb_multi_edge_pulse_sync.sv
// Bench for multi_edge_pulse_sync: rising-edge build and both-edge build side by
// side, checked every cycle against a window-based reference model.
module tb_multi_edge_pulse_sync;

   localparam int W  = 4;
   localparam int SS = 2;
   localparam int FL = 3;
   localparam int CW = 8;
   localparam int SAT = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n, clr;
   logic [W-1:0]    din_a, din_b;
   logic [W-1:0]    dout_a, level_a, ovf_a, dout_b, level_b, ovf_b;
   logic [W*CW-1:0] cnt_a, cnt_b;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   multi_edge_pulse_sync #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER(FL), .EDGE_MODE(0), .CNT_W(CW)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .din_i(din_a), .clr_i(clr),
      .dout_o(dout_a), .level_o(level_a), .cnt_o(cnt_a), .ovf_o(ovf_a));

   multi_edge_pulse_sync #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER(FL), .EDGE_MODE(2), .CNT_W(CW)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .din_i(din_b), .clr_i(clr),
      .dout_o(dout_b), .level_o(level_b), .cnt_o(cnt_b), .ovf_o(ovf_b));

   // Reference model: s is the input delayed SS edges; a level is accepted once
   // the last FL samples since the previous acceptance all disagree with it.
   int m_mode[2] = '{0, 2};
   bit sq[2][W][$];
   bit fw[2][W][$];
   bit m_lvl[2][W];
   bit m_dout[2][W];
   int m_cnt[2][W];
   bit m_ovf[2][W];

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < W; c++) begin
            sq[d][c].delete();
            for (int k = 0; k < SS; k++) sq[d][c].push_back(1'b0);
            fw[d][c].delete();
            m_lvl[d][c] = 0; m_dout[d][c] = 0; m_cnt[d][c] = 0; m_ovf[d][c] = 0;
         end
   endtask

   task automatic model_step(input logic [W-1:0] da, input logic [W-1:0] db, input logic c_clr);
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < W; c++) begin
            bit s, acc, ev;
            s = sq[d][c].pop_front();
            sq[d][c].push_back(d == 0 ? da[c] : db[c]);
            fw[d][c].push_back(s);
            if (fw[d][c].size() > FL) void'(fw[d][c].pop_front());
            acc = (fw[d][c].size() == FL);
            foreach (fw[d][c][j]) if (fw[d][c][j] == m_lvl[d][c]) acc = 0;
            ev = acc && (m_mode[d] == 2 || (m_mode[d] == 0 && !m_lvl[d][c]) ||
                         (m_mode[d] == 1 && m_lvl[d][c]));
            if (acc) begin
               m_lvl[d][c] = !m_lvl[d][c];
               fw[d][c].delete();
            end
            m_dout[d][c] = ev;
            if (c_clr) begin
               m_cnt[d][c] = 0;
               m_ovf[d][c] = 0;
            end
            if (ev) begin
               if (m_cnt[d][c] == SAT) m_ovf[d][c] = 1;
               else                    m_cnt[d][c]++;
            end
         end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_model();
      for (int d = 0; d < 2; d++) begin
         logic [W-1:0]    ed, el, eo;
         logic [W*CW-1:0] ec;
         for (int c = 0; c < W; c++) begin
            ed[c] = m_dout[d][c];
            el[c] = m_lvl[d][c];
            eo[c] = m_ovf[d][c];
            ec[c*CW +: CW] = CW'(m_cnt[d][c]);
         end
         if (d == 0) begin
            chk("model_dout_a", dout_a, ed);  chk("model_level_a", level_a, el);
            chk("model_cnt_a", cnt_a, ec);    chk("model_ovf_a", ovf_a, eo);
         end else begin
            chk("model_dout_b", dout_b, ed);  chk("model_level_b", level_b, el);
            chk("model_cnt_b", cnt_b, ec);    chk("model_ovf_b", ovf_b, eo);
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_step(din_a, din_b, clr);
      else       model_reset();
      @(negedge clk);
      cyc++;
      check_model();
      if ((|dout_a) || (|dout_b))
         $display("[TB] cyc=%0d rst=%0b din_a=%b dout_a=%b din_b=%b dout_b=%b",
                  cyc, rst_n, din_a, dout_a, din_b, dout_b);
   endtask

   typedef struct {
      logic [W-1:0]  din;
      logic          exp_dout;
      logic          exp_level;
      logic [CW-1:0] exp_cnt;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int p2, seen, first_pulse, second_pulse, npulse;
      int phase_a[W], phase_b[W], pulses[W];
      bit done;

      for (int i = 0; i < 12; i++) begin
         tbl[i].din       = (i < 6) ? 4'b0001 : 4'b0000;
         tbl[i].exp_dout  = (i == 4);
         tbl[i].exp_level = (i >= 4 && i <= 9);
         tbl[i].exp_cnt   = (i >= 4) ? 8'd1 : 8'd0;
      end

      rst_n = 1'b0; clr = 1'b0; din_a = '0; din_b = '0;
      model_reset();
      repeat (3) cycle();
      chk("reset_dout", dout_a, 0);  chk("reset_level", level_a, 0);
      chk("reset_cnt", cnt_a, 0);    chk("reset_ovf", ovf_a, 0);

      // 1: single rising event, 5-edge latency, then release
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         din_a = tbl[i].din;
         cycle();
         chk("t1_dout0", dout_a[0], tbl[i].exp_dout);
         chk("t1_level0", level_a[0], tbl[i].exp_level);
         chk("t1_cnt0", cnt_a[CW-1:0], tbl[i].exp_cnt);
      end

      // 2: a 2-cycle glitch is filtered out
      seen = 0;
      din_a = 4'b0010;
      repeat (2) cycle();
      din_a = '0;
      repeat (8) begin
         cycle();
         if (dout_a[1]) seen++;
      end
      chk("t2_no_pulse", seen, 0);
      chk("t2_level1", level_a[1], 0);
      chk("t2_cnt1", cnt_a[CW +: CW], 0);

      // 3: saturation and sticky overflow on channel 2
      p2 = 0;
      for (int n = 0; n < 300; n++) begin
         for (int h = 0; h < 12; h++) begin
            din_a[2] = (h < 6);
            cycle();
            if (dout_a[2]) begin
               p2++;
               if (p2 == 255) begin
                  chk("t3_cnt_at_255", cnt_a[2*CW +: CW], SAT);
                  chk("t3_ovf_at_255", ovf_a[2], 0);
               end
               if (p2 == 256) begin
                  chk("t3_ovf_at_256", ovf_a[2], 1);
                  chk("t3_cnt_at_256", cnt_a[2*CW +: CW], SAT);
               end
            end
         end
      end
      repeat (6) cycle();
      chk("t3_pulses", p2, 300);
      chk("t3_cnt_final", cnt_a[2*CW +: CW], SAT);
      chk("t3_ovf_final", ovf_a[2], 1);

      // 4: clear sampled on the same edge that raises DOUT[3]
      din_a[3] = 1'b1;
      repeat (4) cycle();
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      chk("t4_dout3", dout_a[3], 1);
      chk("t4_cnt_all", cnt_a, 32'h0100_0000);
      chk("t4_ovf_all", ovf_a, 0);
      din_a[3] = 1'b0;
      repeat (8) cycle();

      // 5: both-edge build, 10-cycle high pulse
      npulse = 0; first_pulse = 0; second_pulse = 0;
      din_b[0] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (i == 10) din_b[0] = 1'b0;
         cycle();
         if (dout_b[0]) begin
            npulse++;
            if (npulse == 1) first_pulse = cyc;
            if (npulse == 2) second_pulse = cyc;
         end
      end
      chk("t5_pulses", npulse, 2);
      chk("t5_spacing", second_pulse - first_pulse, 10);
      chk("t5_cnt0", cnt_b[CW-1:0], 2);

      // 6: asynchronous reset with the filter at count 2
      din_a = 4'b0001;
      repeat (4) cycle();
      #2 rst_n = 1'b0;
      din_a = '0;
      #1;
      model_reset();
      chk("t6_dout", dout_a, 0);   chk("t6_level", level_a, 0);
      chk("t6_cnt", cnt_a, 0);     chk("t6_ovf", ovf_a, 0);
      chk("t6_cnt_b", cnt_b, 0);
      repeat (2) cycle();
      rst_n = 1'b1;
      seen = 0;
      repeat (10) begin
         cycle();
         if (|dout_a) seen++;
      end
      chk("t6_no_pulse", seen, 0);

      // Randomised phases on every channel of both builds
      void'($urandom(32'd20240611));
      for (int c = 0; c < W; c++) begin
         phase_a[c] = 0; phase_b[c] = 0; pulses[c] = 0;
      end
      done = 0;
      for (int k = 0; k < 6000 && !done; k++) begin
         for (int c = 0; c < W; c++) begin
            if (phase_a[c] == 0) begin
               din_a[c] = (pulses[c] < 100) ? !din_a[c] : 1'b0;
               if (din_a[c]) pulses[c]++;
               phase_a[c] = $urandom_range(1, 8);
            end else phase_a[c]--;
            if (phase_b[c] == 0) begin
               din_b[c] = !din_b[c];
               phase_b[c] = $urandom_range(1, 8);
            end else phase_b[c]--;
         end
         clr = ($urandom_range(0, 63) == 0);
         cycle();
         done = 1;
         for (int c = 0; c < W; c++) if (pulses[c] < 100 || din_a[c]) done = 0;
      end
      chk("rand_completed", done, 1);
      clr = 1'b0; din_a = '0; din_b = '0;
      repeat (10) cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
